// File: rtl/lbist_misr.sv
// rtl/lbist_misr.sv - LBIST response compactor: MISR over NPAT CUT beats with golden compare
//
// Folds each accepted CUT response vector into a Galois-form multiple-input
// signature register. A session runs from start until NPAT beats are taken.
// At that point done asserts, and pass reports whether the signature matches golden.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a session (honoured in IDLE or DONE)
//   abort      end the session immediately, back to IDLE (wins over start)
//   resp_valid resp carries a CUT response this cycle
//   resp       CUT output vector (WIDTH bits)
//   golden     expected signature, held stable while done=1
//   busy       high while a session is running
//   done       high once NPAT beats have been folded in
//   pass       done && signature == golden
//   signature  current MISR contents
//   beat_cnt   responses accepted this session (saturates at NPAT)

module lbist_misr #(
  parameter int               WIDTH = 2,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'h0000,
  parameter int               NPAT  = 32,
  localparam int              CW    = $clog2(NPAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  input  logic [SIG_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CW-1:0]    beat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(NPAT - 1);
  localparam logic [CW-1:0] ALL_BEATS = CW'(NPAT);

  state_t           state;
  logic [SIG_W-1:0] sig_next;
  logic [SIG_W-1:0] feedback;

  // The shifted-out MSB is not kept; it only decides whether the taps fold in.
  always_comb begin
    feedback = '0;
    if (signature[SIG_W-1]) begin
      feedback = POLY;
    end
    sig_next = {signature[SIG_W-2:0], 1'b0} ^ feedback
             ^ {{(SIG_W - WIDTH){1'b0}}, resp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      signature <= SEED;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            signature <= SEED;
            beat_cnt  <= '0;
          end
        end
        ST_RUN: begin
          // Abort leaves signature and count as they were for debug visibility.
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (resp_valid) begin
            signature <= sig_next;
            if (beat_cnt == LAST_BEAT) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              beat_cnt <= ALL_BEATS;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            signature <= SEED;
            beat_cnt  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pass = done && (signature == golden);

endmodule

// File: tb/tb_lbist_misr.sv
// tb/tb_lbist_misr.sv - scoreboard bench for lbist_misr (NPAT=3/SEED=0 and NPAT=1/SEED=8000)

module tb_lbist_misr;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  cnt;
    logic [15:0] sig;
    logic        pass;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: NPAT=3, SEED=0
  logic        rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, rv_a = 1'b0;
  logic [1:0]  resp_a = 2'b00;
  logic [15:0] golden_a = 16'h000C;
  logic        busy_a, done_a, pass_a;
  logic [15:0] sig_a;
  logic [1:0]  cnt_a;

  // DUT B: NPAT=1, SEED=8000 (feedback path)
  logic        rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0, rv_b = 1'b0;
  logic [1:0]  resp_b = 2'b00;
  logic [15:0] golden_b = 16'h1021;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_b;
  logic        cnt_b;

  lbist_misr #(.WIDTH(2), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .NPAT(3)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
    .resp_valid(rv_a), .resp(resp_a), .golden(golden_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .beat_cnt(cnt_a)
  );

  lbist_misr #(.WIDTH(2), .SIG_W(16), .POLY(16'h1021), .SEED(16'h8000), .NPAT(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
    .resp_valid(rv_b), .resp(resp_b), .golden(golden_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .beat_cnt(cnt_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = '{busy: busy_a, done: done_a, cnt: cnt_a, sig: sig_a, pass: pass_a};
  assign obs_b = '{busy: busy_b, done: done_b, cnt: {1'b0, cnt_b}, sig: sig_b, pass: pass_b};

  int   total = 0;
  int   bad = 0;
  obs_t q_a[$];
  obs_t q_b[$];
  obs_t prev_a, prev_b;
  int   ev_a = 0, ev_b = 0;
  logic mon_en = 1'b0;

  function automatic obs_t mk(input logic b, input logic d, input logic p,
                              input logic [1:0] c, input logic [15:0] s);
    obs_t o;
    o.busy = b; o.done = d; o.pass = p; o.cnt = c; o.sig = s;
    return o;
  endfunction

  function automatic logic changed(input obs_t x, input obs_t y);
    return {x.busy, x.done, x.cnt, x.sig} != {y.busy, y.done, y.cnt, y.sig};
  endfunction

  task automatic compare(input string name, input int id, input int ev,
                         input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d ev%0d got busy=%b done=%b pass=%b cnt=%0d sig=%h want busy=%b done=%b pass=%b cnt=%0d sig=%h",
               name, id, ev, got.busy, got.done, got.pass, got.cnt, got.sig,
               want.busy, want.done, want.pass, want.cnt, want.sig);
    end
  endtask

  // Monitor: any change of busy/done/beat_cnt/signature is a DUT output event
  // and must match the next expected snapshot queued by the stimulus.
  always @(negedge clk) begin
    if (mon_en) begin
      if (changed(obs_a, prev_a)) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event dut0 ev%0d got cnt=%0d sig=%h busy=%b done=%b",
                   ev_a, obs_a.cnt, obs_a.sig, obs_a.busy, obs_a.done);
        end else begin
          compare("sb", 0, ev_a, obs_a, q_a.pop_front());
        end
        ev_a++;
      end
      if (changed(obs_b, prev_b)) begin
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event dut1 ev%0d got cnt=%0d sig=%h busy=%b done=%b",
                   ev_b, obs_b.cnt, obs_b.sig, obs_b.busy, obs_b.done);
        end else begin
          compare("sb", 1, ev_b, obs_b, q_b.pop_front());
        end
        ev_b++;
      end
    end
    prev_a = obs_a;
    prev_b = obs_b;
  end

  task automatic cyc_a(input logic s, input logic ab, input logic v, input logic [1:0] r);
    start_a = s; abort_a = ab; rv_a = v; resp_a = r;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0; rv_a = 1'b0; resp_a = 2'b00;
  endtask

  task automatic cyc_b(input logic s, input logic v, input logic [1:0] r);
    start_b = s; rv_b = v; resp_b = r;
    @(posedge clk); #1;
    start_b = 1'b0; rv_b = 1'b0; resp_b = 2'b00;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  // Canonical stream 11, 01, 10 -> 0x0003, 0x0007, 0x000C, optional gaps.
  task automatic stream_a(input int gap, input logic exp_pass);
    q_a.push_back(mk(1, 0, 0, 2'd1, 16'h0003)); cyc_a(0, 0, 1, 2'b11); idle_a(gap);
    q_a.push_back(mk(1, 0, 0, 2'd2, 16'h0007)); cyc_a(0, 0, 1, 2'b01); idle_a(gap);
    q_a.push_back(mk(0, 1, exp_pass, 2'd3, 16'h000C)); cyc_a(0, 0, 1, 2'b10);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    compare("reset", 0, 0, obs_a, mk(0, 0, 0, 2'd0, 16'h0000));
    compare("reset", 1, 0, obs_b, mk(0, 0, 0, 2'd0, 16'h8000));
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Back-to-back session, golden matches
    golden_a = 16'h000C;
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    stream_a(0, 1'b1);
    idle_a(2);

    // resp_valid in DONE ignored, gapped session, then abort from DONE, resp_valid in IDLE ignored
    cyc_a(0, 0, 1, 2'b11);
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    stream_a(2, 1'b1);
    cyc_a(0, 0, 1, 2'b01);
    q_a.push_back(mk(0, 0, 0, 2'd3, 16'h000C)); cyc_a(0, 1, 0, 2'b00);
    cyc_a(0, 0, 1, 2'b11);
    idle_a(1);

    // Golden mismatch, then restart with matching golden
    golden_a = 16'h000D;
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    stream_a(0, 1'b0);
    idle_a(1);
    golden_a = 16'h000C;
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    stream_a(1, 1'b1);
    idle_a(1);

    // Reset mid-RUN after two beats
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    q_a.push_back(mk(1, 0, 0, 2'd1, 16'h0003)); cyc_a(0, 0, 1, 2'b11);
    q_a.push_back(mk(1, 0, 0, 2'd2, 16'h0007)); cyc_a(0, 0, 1, 2'b01);
    q_a.push_back(mk(0, 0, 0, 2'd0, 16'h0000));
    rst_a = 1'b1; start_a = 1'b1; rv_a = 1'b1; resp_a = 2'b10;
    @(posedge clk); #1;
    rst_a = 1'b0; start_a = 1'b0; rv_a = 1'b0; resp_a = 2'b00;
    idle_a(2);

    // Start pulses during RUN: no reseed, count continues
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    q_a.push_back(mk(1, 0, 0, 2'd1, 16'h0003)); cyc_a(1, 0, 1, 2'b11);
    cyc_a(1, 0, 0, 2'b00);
    q_a.push_back(mk(1, 0, 0, 2'd2, 16'h0007)); cyc_a(0, 0, 1, 2'b01);
    q_a.push_back(mk(0, 1, 1, 2'd3, 16'h000C)); cyc_a(1, 0, 1, 2'b10);
    idle_a(1);

    // Abort after one beat with resp_valid in the abort cycle; then start+abort in IDLE
    q_a.push_back(mk(1, 0, 0, 2'd0, 16'h0000)); cyc_a(1, 0, 0, 2'b00);
    q_a.push_back(mk(1, 0, 0, 2'd1, 16'h0003)); cyc_a(0, 0, 1, 2'b11);
    q_a.push_back(mk(0, 0, 0, 2'd1, 16'h0003)); cyc_a(0, 1, 1, 2'b01);
    cyc_a(1, 1, 1, 2'b10);
    idle_a(3);

    // DUT B: single beat of 00 from seed 0x8000 exercises the POLY feedback
    q_b.push_back(mk(1, 0, 0, 2'd0, 16'h8000)); cyc_b(1, 0, 2'b00);
    q_b.push_back(mk(0, 1, 1, 2'd1, 16'h1021)); cyc_b(0, 1, 2'b00);
    repeat (3) cyc_b(0, 0, 2'b00);

    // Every expected event must have been observed
    total++;
    if (q_a.size() != 0) begin
      bad++;
      $display("FAIL drain dut0 pending=%0d required=0", q_a.size());
    end
    total++;
    if (q_b.size() != 0) begin
      bad++;
      $display("FAIL drain dut1 pending=%0d required=0", q_b.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
